i2c_dac_responder: RTL and testbench
====================================

Name: i2c_dac_responder

Overview:
- I2C target that plays the device end of the link our audio path drives: a 4-channel 12-bit DAC at a 7-bit address.
- Decodes address, multi-write command, high-data and low-data bytes, and ACKs them. Commits each completed 12-bit channel value to a register and emits an update strobe.
- Used as the on-FPGA DAC stand-in for loopback and regression of the audio output path. Also usable as a generic I2C-to-register sink.

Parameters:
- I2C_ADDR, 7'b1100000, 7-bit target address this block answers to.
- FILTER_LEN, 3, number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i2c_scl_IN  input  1  raw SCL from pad.
- i2c_sda_IN  input  1  raw SDA from pad.
- i2c_sda  output  1  open-drain SDA control: 0 = drive low, 1 = release.
- dac_a, dac_b, dac_c, dac_d  output  12 each  last committed value per channel.
- upd_valid  output  1  one-cycle pulse when a channel value is committed.
- upd_channel  output  2  channel index of the commit (0=A..3=D); valid with upd_valid.
- bus_busy  output  1  high from a detected START until a detected STOP.

Behaviour:
- Reset values:
  - i2c_sda=1; dac_a..dac_d=0; upd_valid=0; upd_channel=0; bus_busy=0; state=IDLE.
  - Filtered SCL/SDA = 1; filter counters = 0.
- Input path:
  - Each line passes a 2-flop synchronizer, then the filter. The filtered level flips only after FILTER_LEN consecutive synchronized samples disagree with it.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Edges are detected on the filtered levels only.
- Bus conditions:
  - START = filtered SDA falls while filtered SCL is high.
  - STOP = filtered SDA rises while filtered SCL is high.
  - Both are checked every cycle and override the state machine in any state, including ACK states.
  - START (or repeated START) goes to ADDR with bit count 0 and the partial triplet discarded; bus_busy=1.
  - STOP goes to IDLE, releases SDA, discards the partial triplet; bus_busy=0.
- Bit transfer:
  - Data bits are sampled on filtered SCL rising edges, MSB first, into an 8-bit shift register.
  - The byte completes on the 8th rising edge.
- ACK handling:
  - If the byte is to be ACKed, i2c_sda=0 starting the cycle after the 8th SCL falling edge, and is held through the 9th clock.
  - SDA is released the cycle after the 9th SCL falling edge.
  - NACK = SDA stays released.
- State machine: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, HI, HI_ACK, LO, LO_ACK, IGNORE.
  - ADDR: byte[7:1]==I2C_ADDR and byte[0]==0 → ACK, go to CMD. Mismatch or read bit set → NACK, go to IGNORE.
  - CMD: byte[7:3]==5'b01000 → ACK, latch channel=byte[2:1], go to HI; byte[0] is ignored. Any other command → NACK, go to IGNORE.
  - HI: always ACK; latch value[11:8]=byte[3:0]; byte[7:4] ignored; go to LO.
  - LO: always ACK; value[7:0]=byte. At the end of LO_ACK (cycle after the 9th SCL falling edge):
    - dac_<channel> <= value;
    - upd_valid=1 for exactly one cycle, with upd_channel=channel;
    - state goes to CMD, so further triplets in the same transaction are accepted.
  - IGNORE: never drives SDA; waits for START or STOP.
  - IDLE: only START is acted on; SCL toggling without a START has no effect.
- Simultaneous events:
  - START/STOP detected in the same cycle as a byte-complete edge wins; no ACK is driven.
  - A commit and a STOP in the same cycle cannot occur, since a STOP needs SCL high.
- Reset mid-transfer: SDA released the same cycle reset is sampled; all state and registers return to reset values; no upd_valid pulse.
- Latency from pad edge to internal edge: 2 + FILTER_LEN cycles.
- SCL period on the bench must be ≥ 4×(2+FILTER_LEN) clk cycles; slower is always legal.

Test Plan:
- START, 0xC0, 0x40, 0x0F, 0xFF, STOP → ACK on all 4 bytes; dac_a=0xFFF; one upd_valid with upd_channel=0; bus_busy falls after STOP.
- START, 0xC2 (address 0x61), 0x42, 0x01, 0x23, STOP → address NACK; no SDA drive for the rest; all dac regs unchanged; no upd_valid.
- START, 0xC0, 0x42, 0xA1, 0x23, 0x44, 0x04, 0x56, STOP → dac_b=0x123 then dac_c=0x456; two pulses with upd_channel 1 then 2.
- START, 0xC0, 0x46, 0x0A, STOP, then START, 0xC1 → no update to dac_d; 0xC1 (read) NACKed.
- 1-cycle and (FILTER_LEN-1)-cycle low glitches on SCL during the HI byte of a channel-D write of 0x5A5 → glitches ignored; dac_d=0x5A5.
- Assert reset for 1 cycle while SDA is driven low during CMD_ACK → i2c_sda=1 next cycle; dac regs=0; state IDLE; the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_dac_responder.sv
// i2c_dac_responder
//   I2C target acting as the device end of a 4-channel 12-bit DAC.
//   Accepts write transactions of the form
//     START, {I2C_ADDR,0}, cmd, hi, lo, [cmd, hi, lo ...], STOP
//   and ACKs each accepted byte. A completed triplet commits a 12-bit value
//   to the selected channel register and pulses upd_valid for one cycle.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   i2c_scl_IN   raw SCL from pad
//   i2c_sda_IN   raw SDA from pad
//   i2c_sda      open-drain SDA control (0 = drive low, 1 = release)
//   dac_a..dac_d last committed value per channel
//   upd_valid    one-cycle pulse when a channel value is committed
//   upd_channel  channel index of the commit (0=A..3=D)
//   bus_busy     high from a detected START until a detected STOP
module i2c_dac_responder #(
  parameter logic [6:0]  I2C_ADDR   = 7'b1100000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_scl_IN,
  input  logic        i2c_sda_IN,
  output logic        i2c_sda,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] dac_c,
  output logic [11:0] dac_d,
  output logic        upd_valid,
  output logic [1:0]  upd_channel,
  output logic        bus_busy
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_CMD      = 4'd3,
    ST_CMD_ACK  = 4'd4,
    ST_HI       = 4'd5,
    ST_HI_ACK   = 4'd6,
    ST_LO       = 4'd7,
    ST_LO_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_t;

  // Count value at which one more disagreeing sample flips the filtered level.
  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

  // Synchronizer and filter state
  logic       scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_prev_q, sda_prev_q;

  // Protocol state
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       drive_q, drive_d;
  logic [1:0] channel_q, channel_d;
  logic [11:0] value_q, value_d;
  logic       busy_q, busy_d;
  logic [11:0] dac_a_q, dac_a_d, dac_b_q, dac_b_d, dac_c_q, dac_c_d, dac_d_q, dac_d_d;
  logic       upd_valid_q, upd_valid_d;
  logic [1:0] upd_channel_q, upd_channel_d;

  // Edge and bus-condition decode on the filtered levels
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] byte_s;

  assign scl_rise_s = scl_f_q & ~scl_prev_q;
  assign scl_fall_s = ~scl_f_q & scl_prev_q;
  assign start_s    = sda_prev_q & ~sda_f_q & scl_f_q;
  assign stop_s     = ~sda_prev_q & sda_f_q & scl_f_q;
  // Byte as it stands once the current rising-edge bit is shifted in.
  assign byte_s     = {shift_q[6:0], sda_f_q};

  // Glitch filters: level flips only after FILTER_LEN disagreeing samples.
  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = 4'd0;
    sda_f_d   = sda_f_q;
    sda_cnt_d = 4'd0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == FLT_LAST) begin
        scl_f_d = scl_s2_q;
      end else begin
        scl_cnt_d = scl_cnt_q + 4'd1;
      end
    end else begin
      scl_cnt_d = 4'd0;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == FLT_LAST) begin
        sda_f_d = sda_s2_q;
      end else begin
        sda_cnt_d = sda_cnt_q + 4'd1;
      end
    end else begin
      sda_cnt_d = 4'd0;
    end
  end

  // Next-state logic for the protocol FSM, ACK drive and channel commit.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    drive_d       = drive_q;
    channel_d     = channel_q;
    value_d       = value_q;
    busy_d        = busy_q;
    dac_a_d       = dac_a_q;
    dac_b_d       = dac_b_q;
    dac_c_d       = dac_c_q;
    dac_d_d       = dac_d_q;
    upd_valid_d   = 1'b0;
    upd_channel_d = upd_channel_q;

    if (start_s) begin
      // START / repeated START wins over everything, including ACK phases.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      drive_d   = 1'b0;
      value_d   = 12'd0;
      busy_d    = 1'b1;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      drive_d   = 1'b0;
      value_d   = 12'd0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_CMD, ST_HI, ST_LO: begin
          if (scl_rise_s) begin
            shift_d = byte_s;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              case (state_q)
                ST_ADDR: begin
                  if ((byte_s[7:1] == I2C_ADDR) && (byte_s[0] == 1'b0)) begin
                    state_d = ST_ADDR_ACK;
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_CMD: begin
                  if (byte_s[7:3] == 5'b01000) begin
                    channel_d = byte_s[2:1];
                    state_d   = ST_CMD_ACK;
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_HI: begin
                  value_d[11:8] = byte_s[3:0];
                  state_d       = ST_HI_ACK;
                end
                ST_LO: begin
                  value_d[7:0] = byte_s;
                  state_d      = ST_LO_ACK;
                end
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_ADDR_ACK, ST_CMD_ACK, ST_HI_ACK, ST_LO_ACK: begin
          // First falling edge here is the 8th (start driving); the next
          // one is the 9th (release and move on).
          if (scl_fall_s) begin
            if (!drive_q) begin
              drive_d = 1'b1;
            end else begin
              drive_d = 1'b0;
              case (state_q)
                ST_ADDR_ACK: state_d = ST_CMD;
                ST_CMD_ACK:  state_d = ST_HI;
                ST_HI_ACK:   state_d = ST_LO;
                ST_LO_ACK: begin
                  state_d       = ST_CMD;
                  upd_valid_d   = 1'b1;
                  upd_channel_d = channel_q;
                  case (channel_q)
                    2'd0:    dac_a_d = value_q;
                    2'd1:    dac_b_d = value_q;
                    2'd2:    dac_c_d = value_q;
                    2'd3:    dac_d_d = value_q;
                    default: dac_a_d = dac_a_q;
                  endcase
                end
                default: state_d = ST_IGNORE;
              endcase
            end
          end else begin
            drive_d = drive_q;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          drive_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end
  end

  // Register stage: synchronizers, filters, FSM and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q      <= 1'b1;
      scl_s2_q      <= 1'b1;
      sda_s1_q      <= 1'b1;
      sda_s2_q      <= 1'b1;
      scl_f_q       <= 1'b1;
      sda_f_q       <= 1'b1;
      scl_cnt_q     <= 4'd0;
      sda_cnt_q     <= 4'd0;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'd0;
      drive_q       <= 1'b0;
      channel_q     <= 2'd0;
      value_q       <= 12'd0;
      busy_q        <= 1'b0;
      dac_a_q       <= 12'd0;
      dac_b_q       <= 12'd0;
      dac_c_q       <= 12'd0;
      dac_d_q       <= 12'd0;
      upd_valid_q   <= 1'b0;
      upd_channel_q <= 2'd0;
    end else begin
      scl_s1_q      <= i2c_scl_IN;
      scl_s2_q      <= scl_s1_q;
      sda_s1_q      <= i2c_sda_IN;
      sda_s2_q      <= sda_s1_q;
      scl_f_q       <= scl_f_d;
      sda_f_q       <= sda_f_d;
      scl_cnt_q     <= scl_cnt_d;
      sda_cnt_q     <= sda_cnt_d;
      scl_prev_q    <= scl_f_q;
      sda_prev_q    <= sda_f_q;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      drive_q       <= drive_d;
      channel_q     <= channel_d;
      value_q       <= value_d;
      busy_q        <= busy_d;
      dac_a_q       <= dac_a_d;
      dac_b_q       <= dac_b_d;
      dac_c_q       <= dac_c_d;
      dac_d_q       <= dac_d_d;
      upd_valid_q   <= upd_valid_d;
      upd_channel_q <= upd_channel_d;
    end
  end

  assign i2c_sda     = ~drive_q;
  assign dac_a       = dac_a_q;
  assign dac_b       = dac_b_q;
  assign dac_c       = dac_c_q;
  assign dac_d       = dac_d_q;
  assign upd_valid   = upd_valid_q;
  assign upd_channel = upd_channel_q;
  assign bus_busy    = busy_q;

endmodule

// File: tb/tb_i2c_dac_responder.sv
// Directed bench for i2c_dac_responder: a bit-banged I2C controller drives the
// pads (wired-AND with the DUT's open-drain SDA) and checks ACKs, channel
// registers, update pulses and bus_busy against hand-computed values.
module tb_i2c_dac_responder;

  localparam int FL = 3;
  localparam int Q  = 10;  // quarter SCL period in clk cycles (period 40 >= 4*(2+FL))

  logic        clk = 1'b0;
  logic        reset;
  logic        scl_m, sda_m;
  logic        sda_line;
  logic        i2c_sda;
  logic [11:0] dac_a, dac_b, dac_c, dac_d;
  logic        upd_valid;
  logic [1:0]  upd_channel;
  logic        bus_busy;

  int total = 0;
  int bad   = 0;

  // Monitors
  int         upd_cnt   = 0;
  int         drive_cnt = 0;
  int         wide_cnt  = 0;
  logic       upd_prev  = 1'b0;
  logic [1:0] ch_log [0:15];

  assign sda_line = sda_m & i2c_sda;

  i2c_dac_responder #(.I2C_ADDR(7'b1100000), .FILTER_LEN(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_scl_IN (scl_m),
    .i2c_sda_IN (sda_line),
    .i2c_sda    (i2c_sda),
    .dac_a      (dac_a),
    .dac_b      (dac_b),
    .dac_c      (dac_c),
    .dac_d      (dac_d),
    .upd_valid  (upd_valid),
    .upd_channel(upd_channel),
    .bus_busy   (bus_busy)
  );

  always #5 clk = ~clk;

  // Log update pulses, SDA drive cycles and over-long pulses.
  always @(posedge clk) begin
    upd_prev <= upd_valid;
    if (upd_valid) begin
      ch_log[upd_cnt[3:0]] <= upd_channel;
      upd_cnt <= upd_cnt + 1;
    end
    if (upd_valid && upd_prev) wide_cnt <= wide_cnt + 1;
    if (!i2c_sda) drive_cnt <= drive_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(Q);
  endtask

  // Eight data bits, MSB first; optional SCL-low glitches inside bit 4's high phase.
  task automatic send_bits(input logic [7:0] b, input bit glitch);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_cyc(Q);
      scl_m = 1'b1;
      if (glitch && i == 4) begin
        wait_cyc(4);
        scl_m = 1'b0; wait_cyc(1);
        scl_m = 1'b1; wait_cyc(5);
        scl_m = 1'b0; wait_cyc(FL - 1);
        scl_m = 1'b1; wait_cyc(2 * Q - 10 - (FL - 1));
      end else begin
        wait_cyc(2 * Q);
      end
      scl_m = 1'b0; wait_cyc(Q);
    end
  endtask

  // Ninth clock with SDA released; ack = line low in mid high phase.
  task automatic ack_clock(output bit ack);
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    ack = ~sda_line; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic wr(input logic [7:0] b, input bit exp_ack, input string tag);
    bit ack;
    send_bits(b, 1'b0);
    ack_clock(ack);
    check(tag, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  initial begin
    int  p0;
    int  d0;
    bit  ack;
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_cyc(5);
    check("rst_sda", {31'd0, i2c_sda}, 32'd1);
    check("rst_dac_a", {20'd0, dac_a}, 32'd0);
    check("rst_dac_d", {20'd0, dac_d}, 32'd0);
    check("rst_upd", {31'd0, upd_valid}, 32'd0);
    check("rst_upd_ch", {30'd0, upd_channel}, 32'd0);
    check("rst_busy", {31'd0, bus_busy}, 32'd0);
    reset = 1'b0;
    wait_cyc(20);

    // T1: channel A <= 0xFFF
    p0 = upd_cnt;
    i2c_start();
    check("t1_busy_hi", {31'd0, bus_busy}, 32'd1);
    wr(8'hC0, 1'b1, "t1_ack_addr");
    wr(8'h40, 1'b1, "t1_ack_cmd");
    wr(8'h0F, 1'b1, "t1_ack_hi");
    wr(8'hFF, 1'b1, "t1_ack_lo");
    i2c_stop();
    wait_cyc(Q);
    check("t1_dac_a", {20'd0, dac_a}, 32'hFFF);
    check("t1_pulses", upd_cnt - p0, 32'd1);
    check("t1_ch", {30'd0, ch_log[p0[3:0]]}, 32'd0);
    check("t1_busy_lo", {31'd0, bus_busy}, 32'd0);

    // T2: wrong address -> NACK, never drives SDA
    p0 = upd_cnt;
    d0 = drive_cnt;
    i2c_start();
    wr(8'hC2, 1'b0, "t2_nack_addr");
    wr(8'h42, 1'b0, "t2_nack_cmd");
    wr(8'h01, 1'b0, "t2_nack_hi");
    wr(8'h23, 1'b0, "t2_nack_lo");
    i2c_stop();
    wait_cyc(Q);
    check("t2_no_drive", drive_cnt - d0, 32'd0);
    check("t2_pulses", upd_cnt - p0, 32'd0);
    check("t2_dac_a", {20'd0, dac_a}, 32'hFFF);
    check("t2_dac_b", {20'd0, dac_b}, 32'd0);

    // T3: two triplets in one transaction
    p0 = upd_cnt;
    i2c_start();
    wr(8'hC0, 1'b1, "t3_ack_addr");
    wr(8'h42, 1'b1, "t3_ack_cmd1");
    wr(8'hA1, 1'b1, "t3_ack_hi1");
    wr(8'h23, 1'b1, "t3_ack_lo1");
    check("t3_dac_b_mid", {20'd0, dac_b}, 32'h123);
    wr(8'h44, 1'b1, "t3_ack_cmd2");
    wr(8'h04, 1'b1, "t3_ack_hi2");
    wr(8'h56, 1'b1, "t3_ack_lo2");
    i2c_stop();
    wait_cyc(Q);
    check("t3_dac_b", {20'd0, dac_b}, 32'h123);
    check("t3_dac_c", {20'd0, dac_c}, 32'h456);
    check("t3_pulses", upd_cnt - p0, 32'd2);
    check("t3_ch0", {30'd0, ch_log[p0[3:0]]}, 32'd1);
    p0 = p0 + 1;
    check("t3_ch1", {30'd0, ch_log[p0[3:0]]}, 32'd2);

    // T4: partial triplet aborted by STOP, then a read address
    p0 = upd_cnt;
    i2c_start();
    wr(8'hC0, 1'b1, "t4_ack_addr");
    wr(8'h46, 1'b1, "t4_ack_cmd");
    wr(8'h0A, 1'b1, "t4_ack_hi");
    i2c_stop();
    i2c_start();
    wr(8'hC1, 1'b0, "t4_nack_read");
    i2c_stop();
    wait_cyc(Q);
    check("t4_dac_d", {20'd0, dac_d}, 32'd0);
    check("t4_pulses", upd_cnt - p0, 32'd0);

    // T5: SCL glitches inside the HI byte are filtered out
    p0 = upd_cnt;
    i2c_start();
    wr(8'hC0, 1'b1, "t5_ack_addr");
    wr(8'h46, 1'b1, "t5_ack_cmd");
    send_bits(8'h05, 1'b1);
    ack_clock(ack);
    check("t5_ack_hi", {31'd0, ack}, 32'd1);
    wr(8'hA5, 1'b1, "t5_ack_lo");
    i2c_stop();
    wait_cyc(Q);
    check("t5_dac_d", {20'd0, dac_d}, 32'h5A5);
    check("t5_pulses", upd_cnt - p0, 32'd1);
    check("t5_ch", {30'd0, ch_log[p0[3:0]]}, 32'd3);

    // T6: reset during CMD_ACK
    p0 = upd_cnt;
    i2c_start();
    wr(8'hC0, 1'b1, "t6_ack_addr");
    send_bits(8'h40, 1'b0);
    check("t6_sda_driven", {31'd0, i2c_sda}, 32'd0);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("t6_sda_released", {31'd0, i2c_sda}, 32'd1);
    check("t6_dac_a", {20'd0, dac_a}, 32'd0);
    check("t6_dac_b", {20'd0, dac_b}, 32'd0);
    check("t6_dac_c", {20'd0, dac_c}, 32'd0);
    check("t6_dac_d", {20'd0, dac_d}, 32'd0);
    check("t6_busy", {31'd0, bus_busy}, 32'd0);
    ack_clock(ack);
    check("t6_idle_no_ack", {31'd0, ack}, 32'd0);
    check("t6_no_pulse", upd_cnt - p0, 32'd0);
    i2c_start();
    wr(8'hC0, 1'b1, "t6_ack_addr2");
    wr(8'h44, 1'b1, "t6_ack_cmd2");
    wr(8'h07, 1'b1, "t6_ack_hi2");
    wr(8'h89, 1'b1, "t6_ack_lo2");
    i2c_stop();
    wait_cyc(Q);
    check("t6_dac_c_new", {20'd0, dac_c}, 32'h789);
    check("t6_pulses", upd_cnt - p0, 32'd1);
    check("t6_ch", {30'd0, ch_log[p0[3:0]]}, 32'd2);
    check("pulse_width", wide_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
